tick_divider: RTL and testbench
===============================

TICK_DIVIDER -- requirements
Module: tick_divider

Interface
REQ-001 Parameter WIDTH, default 28: width of the counter, the divisor register and DIV_IN.
REQ-002 Parameter DEFAULT_DIV, default 100000000: divisor loaded at reset; SHALL be in the range 2..2^WIDTH-1.
REQ-003 CLK  input  1: single clock; all state updates on the rising edge.
REQ-004 CLR_L  input  1: reset, synchronous, active-low.
REQ-005 EN  input  1: count enable; when low, all state holds.
REQ-006 MODE  input  1: 0 = periodic, 1 = one-shot.
REQ-007 START  input  1: one-shot trigger pulse; ignored in periodic mode.
REQ-008 LD_L  input  1: synchronous active-low load of DIV_IN into the divisor register.
REQ-009 DIV_IN  input  WIDTH: new divisor value.
REQ-010 Q  output  WIDTH: registered count value.
REQ-011 TICK  output  1: single-cycle terminal-count pulse (cascade/enable output).
REQ-012 SQ  output  1: registered square wave, period equal to the divisor.
REQ-013 BUSY  output  1: high while the FSM is in RUN.

Function
REQ-014 The divisor register DIVR SHALL hold the active divisor; the count runs 0..DIVR-1 and wraps to 0.
REQ-015 The FSM SHALL have states IDLE and RUN.
- Periodic mode: IDLE->RUN on the first enabled cycle.
- One-shot mode: IDLE->RUN on START=1 with EN=1.
- One-shot mode: RUN->IDLE on the cycle Q wraps from DIVR-1 to 0.
- Periodic mode: stays in RUN.
REQ-016 In RUN with EN=1, Q SHALL increment by 1 per clock; in IDLE, Q SHALL hold 0.
REQ-017 TICK SHALL be a combinational decode of registered state: TICK = EN & RUN & (Q==DIVR-1) & LD_L; exactly one cycle wide per period when EN is held high.
REQ-018 SQ SHALL be registered and equal (Qnext >= DIVR>>1), so it changes in the same cycle as Q.
- Odd DIVR: low for DIVR>>1 cycles, high for the remainder.
- SQ SHALL be 0 in IDLE.
REQ-019 LD_L=0 SHALL take effect on the next edge regardless of EN.
- DIVR <= max(DIV_IN, 2).
- Q <= 0, SQ <= 0.
- The FSM goes to IDLE in one-shot mode and RUN in periodic mode.
REQ-020 DIV_IN of 0 or 1 SHALL be clamped to 2; no other arithmetic saturation is needed.
REQ-021 Priority SHALL be CLR_L > LD_L > START > count.
- START while already in RUN SHALL be ignored; it does not restart the count.
REQ-022 EN=0 mid-period SHALL freeze Q, SQ and the FSM, and force TICK low; counting resumes from the frozen Q.
REQ-023 A MODE change SHALL take effect at the next wrap; an in-progress one-shot period completes.
REQ-024 BUSY SHALL be registered and equal (state==RUN).

Reset
REQ-025 While CLR_L=0 at a rising edge, the following SHALL apply; the divisor loaded via LD_L is lost.
- Q <= 0, SQ <= 0, BUSY <= 0, state <= IDLE.
- DIVR <= DEFAULT_DIV.
REQ-026 TICK SHALL be 0 in the cycle following reset.
REQ-027 Reset mid-period SHALL abort the period with no TICK.
REQ-028 There SHALL be no asynchronous reset path.

Structure
REQ-029 Shared package tick_div_pkg SHALL hold the FSM state encoding (IDLE=0, RUN=1), constant MIN_DIV=2 and the MODE encodings.
REQ-030 Sub-module div_count SHALL implement the WIDTH-bit counter with sync clear, enable and terminal-count compare.
- tick_divider instantiates it once.
- tick_divider owns DIVR, the FSM and SQ.
REQ-031 A cascade of two tick_dividers, where TICK of the first drives EN of the second, SHALL be legal and glitch-free.

Verification (run with WIDTH=8, DEFAULT_DIV=10)
REQ-032 Periodic default: reset, then EN=1 for 40 cycles.
- Q runs 0..9 repeating.
- TICK pulses at cycles 10, 20, 30, 40.
- SQ is low for 5 cycles and high for 5 cycles.
REQ-033 Load and clamp:
- LD_L=0 with DIV_IN=7 -> period 7; SQ low 3 cycles, high 4 cycles.
- LD_L=0 with DIV_IN=0 -> period 2; TICK every other cycle.
REQ-034 One-shot:
- MODE=1, START pulse -> BUSY high for 10 cycles and one TICK, then Q=0 and BUSY=0.
- A second START during RUN has no effect.
REQ-035 Enable gating: EN=0 for 5 cycles at Q=4.
- Q holds at 4 and TICK stays 0.
- The next TICK is delayed by exactly 5 cycles.
REQ-036 Collisions:
- LD_L=0 at Q=9 -> TICK suppressed and Q=0 next cycle.
- CLR_L=0 at Q=6 after DIV_IN=20 was loaded -> DIVR returns to 10 and Q=0.

Source files
------------

// File: rtl/tick_div_pkg.sv
// tick_div_pkg: shared FSM, mode and divisor encodings for tick_divider
package tick_div_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    localparam int MIN_DIV = 2;
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
endpackage

// File: rtl/tick_divider_div_count.sv
// div_count: WIDTH-bit wrapping counter with sync clear, enable and terminal-count compare
module div_count #(
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] lim,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt,
    output logic             tc
);
    assign tc  = q == lim - 1'b1;
    assign nxt = tc ? '0 : q + 1'b1;
    always_ff @(posedge clk) begin
        if (clr) q <= '0;
        else if (en) q <= nxt;
    end
endmodule

// File: rtl/tick_divider.sv
// tick_divider: programmable divider producing a terminal-count tick and square wave,
// in periodic or one-shot mode
module tick_divider
    import tick_div_pkg::*;
#(
    parameter int WIDTH       = 28,
    parameter int DEFAULT_DIV = 100000000
) (
    input  logic             clk,
    input  logic             clr_l,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    input  logic             ld_l,
    input  logic [WIDTH-1:0] div_in,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             sq,
    output logic             busy
);
    state_t           state;
    logic [WIDTH-1:0] divr, q_next;
    logic             tc, run;
    assign run  = state == RUN;
    assign tick = en & run & tc & ld_l;
    div_count #(.WIDTH(WIDTH)) u_cnt (
        .clk (clk),
        .clr (!clr_l | !ld_l),
        .en  (en & run & ld_l),
        .lim (divr),
        .q   (q),
        .nxt (q_next),
        .tc  (tc)
    );
    // The IDLE->RUN transition itself does not count; Q starts at 0 in RUN.
    always_ff @(posedge clk) begin
        if (!clr_l) begin
            state <= IDLE;
            divr  <= WIDTH'(DEFAULT_DIV);
            sq    <= 1'b0;
            busy  <= 1'b0;
        end else if (!ld_l) begin
            divr  <= (div_in < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : div_in;
            sq    <= 1'b0;
            state <= (mode == MODE_ONESHOT) ? IDLE : RUN;
            busy  <= mode != MODE_ONESHOT;
        end else if (en && run) begin
            sq <= q_next >= (divr >> 1);
            if (tc) begin
                state <= (mode == MODE_ONESHOT) ? IDLE : RUN;
                busy  <= mode != MODE_ONESHOT;
            end
        end else if (en && (mode == MODE_PERIODIC || start)) begin
            state <= RUN;
            busy  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tick_divider.sv
// tb_tick_divider: directed stimulus with a period-position reference model checked every cycle
module tb_tick_divider;
    logic       clk = 1'b0;
    logic       clr_l = 1'b0, en = 1'b0, mode = 1'b0, start = 1'b0, ld_l = 1'b1;
    logic [7:0] div_in = '0;
    logic [7:0] q;
    logic       tick, sq, busy;
    int         checks = 0, failures = 0;
    int         m_d = 10, m_p = 0;
    bit         m_run = 1'b0, live = 1'b0;

    tick_divider #(.WIDTH(8), .DEFAULT_DIV(10)) dut (
        .clk(clk), .clr_l(clr_l), .en(en), .mode(mode), .start(start),
        .ld_l(ld_l), .div_in(div_in), .q(q), .tick(tick), .sq(sq), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: position within the period, divisor and whether a period is active.
    always @(posedge clk) begin
        if (!clr_l) begin
            m_d <= 10; m_p <= 0; m_run <= 1'b0;
        end else if (!ld_l) begin
            m_d <= (div_in < 2) ? 2 : int'(div_in); m_p <= 0; m_run <= !mode;
        end else if (en && m_run) begin
            m_p <= (m_p + 1) % m_d;
            if (m_p == m_d - 1 && mode) m_run <= 1'b0;
        end else if (en && (!mode || start)) m_run <= 1'b1;
    end

    always @(negedge clk) begin
        if (live) begin
            chk("model_q", int'(q), m_p);
            chk("model_tick", int'(tick), int'(en && m_run && m_p == m_d - 1 && ld_l));
            chk("model_sq", int'(sq), int'(m_p >= m_d / 2));
            chk("model_busy", int'(busy), int'(m_run));
        end
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_q(input int v);
        int k;
        for (k = 0; k < 50 && int'(q) != v; k++) adv(1);
        chk("wait_q_reached", int'(q), v);
    endtask

    task automatic next_tick(output int n);
        n = 0;
        #1;
        while (!tick && n < 60) begin
            adv(1); #1; n++;
        end
    endtask

    task automatic do_reset();
        clr_l = 1'b0; adv(1); clr_l = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ticks[$];
        int sqh, lo, hi, nb, nt, a, b;
        adv(2);
        live = 1'b1;
        #1;
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_sq", int'(sq), 0);
        chk("reset_tick", int'(tick), 0);
        // Periodic default divide-by-10
        clr_l = 1'b1; en = 1'b1;
        sqh = 0;
        for (int i = 0; i <= 40; i++) begin
            #1;
            if (tick) ticks.push_back(i);
            if (i >= 11 && i <= 20) sqh += int'(sq);
            if (i == 15) chk("periodic_q_at15", int'(q), 4);
            adv(1);
        end
        chk("periodic_tick_count", ticks.size(), 4);
        for (int i = 0; i < 4 && i < ticks.size(); i++) chk("periodic_tick_at", ticks[i], 10 * (i + 1));
        chk("periodic_sq_high", sqh, 5);
        // Load divisor 7
        ld_l = 1'b0; div_in = 8'd7; adv(1); ld_l = 1'b1;
        ticks.delete(); lo = 0; hi = 0;
        for (int j = 0; j < 14; j++) begin
            #1;
            if (tick) ticks.push_back(j);
            if (j < 7) begin
                if (sq) hi++; else lo++;
            end
            adv(1);
        end
        chk("load7_sq_low", lo, 3);
        chk("load7_sq_high", hi, 4);
        chk("load7_tick_count", ticks.size(), 2);
        if (ticks.size() > 0) chk("load7_first_tick", ticks[0], 6);
        // Clamp of divisor 0 to 2
        ld_l = 1'b0; div_in = 8'd0; adv(1); ld_l = 1'b1;
        ticks.delete();
        for (int j = 0; j < 8; j++) begin
            #1;
            if (tick) ticks.push_back(j);
            adv(1);
        end
        chk("clamp_tick_count", ticks.size(), 4);
        if (ticks.size() > 0) chk("clamp_first_tick", ticks[0], 1);
        // One-shot with a redundant START mid-run
        do_reset(); mode = 1'b1;
        adv(3); #1;
        chk("oneshot_idle_busy", int'(busy), 0);
        chk("oneshot_idle_q", int'(q), 0);
        start = 1'b1; adv(1); start = 1'b0;
        nb = 0; nt = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            nb += int'(busy);
            nt += int'(tick);
            start = (i == 4);
            adv(1);
        end
        start = 1'b0;
        chk("oneshot_busy_cycles", nb, 10);
        chk("oneshot_ticks", nt, 1);
        chk("oneshot_end_q", int'(q), 0);
        chk("oneshot_end_busy", int'(busy), 0);
        // Enable gating at Q=4
        mode = 1'b0; do_reset();
        wait_q(4);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("gate_q_hold", int'(q), 4);
            chk("gate_tick_low", int'(tick), 0);
            adv(1);
        end
        en = 1'b1;
        next_tick(a);
        chk("gate_resume_cycles", a, 5);
        adv(1);
        // Load at Q=9 suppresses the tick
        wait_q(9);
        ld_l = 1'b0; div_in = 8'd10; #1;
        chk("ld_collision_tick", int'(tick), 0);
        adv(1); ld_l = 1'b1; #1;
        chk("ld_collision_q", int'(q), 0);
        // Reset at Q=6 after loading 20 restores the default divisor
        ld_l = 1'b0; div_in = 8'd20; adv(1); ld_l = 1'b1;
        wait_q(6);
        clr_l = 1'b0; adv(1); clr_l = 1'b1; #1;
        chk("clr_collision_q", int'(q), 0);
        chk("clr_after_tick", int'(tick), 0);
        next_tick(a);
        chk("clr_first_tick", a, 10);
        adv(1);
        next_tick(b);
        chk("clr_period", b + 1, 10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
